// File: rtl/shiftadd_pkg.sv
// Shared definitions for the shift-and-add multiplier and the downstream
// reducer. Both ends of the start/x/valid handshake import this package so
// widths and state encodings cannot drift apart.
package shiftadd_pkg;

  // Unreduced product width and the reducer's folding chunk width.
  localparam int DATA_LENGTH  = 64;
  localparam int CHUNK_LENGTH = 32;

  // Multiplier sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } mul_state_e;

  // Reducer sequencing states, kept here so both ends share one definition.
  typedef enum logic [1:0] {
    RED_IDLE = 2'd0,
    RED_LOAD = 2'd1,
    RED_FOLD = 2'd2,
    RED_DONE = 2'd3
  } red_state_e;

endpackage

// File: rtl/shiftadd_pp_gen.sv
// Partial-product generator: one RADIX_BITS-wide multiplier digit times the
// already-shifted multiplicand, formed at full product width so the
// accumulator add never needs a separate extension step.
module shiftadd_pp_gen #(
  parameter int RADIX_BITS  = 1,
  parameter int DATA_LENGTH = 64
) (
  input  logic [RADIX_BITS-1:0]  digit_i,
  input  logic [DATA_LENGTH-1:0] mcand_i,
  output logic [DATA_LENGTH-1:0] pp_o
);

  // Digit is zero-extended so the product stays unsigned.
  always_comb begin
    pp_o = mcand_i * DATA_LENGTH'(digit_i);
  end

endmodule

// File: rtl/shiftadd_mul_serialized.sv
// Serial shift-and-add multiplier feeding the reducer. Consumes RADIX_BITS
// multiplier bits per cycle, presents the product on a registered x_o with a
// single start_o pulse, then waits for the reducer's done_i before accepting
// new work.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; start_i latches operands
// MUL   | one digit per cycle accumulated, STEPS cycles, fixed latency
// ISSUE | start_o pulse for one cycle, x_o already holds the product
// WAIT  | reducer busy on x_o; leave on done_i
module shiftadd_mul_serialized #(
  parameter int DATA_LENGTH    = shiftadd_pkg::DATA_LENGTH,
  parameter int OPERAND_LENGTH = 32,
  parameter int RADIX_BITS     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [OPERAND_LENGTH-1:0] a_i,
  input  logic [OPERAND_LENGTH-1:0] b_i,
  output logic                      ready_o,
  output logic [DATA_LENGTH-1:0]    x_o,
  output logic                      start_o,
  input  logic                      done_i,
  output logic                      busy_o
);

  import shiftadd_pkg::*;

  localparam int STEPS = OPERAND_LENGTH / RADIX_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  mul_state_e state_q, state_d;

  logic [DATA_LENGTH-1:0]    acc_q, acc_d;
  logic [DATA_LENGTH-1:0]    mcand_q, mcand_d;
  logic [OPERAND_LENGTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0]    x_q, x_d;
  logic [DATA_LENGTH-1:0]    pp;
  logic [DATA_LENGTH-1:0]    acc_sum;
  logic                      accept;
  logic                      last_step;

  assign accept    = (state_q == IDLE) && start_i;
  assign last_step = (cnt_q == LAST_STEP);
  assign acc_sum   = acc_q + pp;

  shiftadd_pp_gen #(
    .RADIX_BITS (RADIX_BITS),
    .DATA_LENGTH(DATA_LENGTH)
  ) u_pp_gen (
    .digit_i(mplier_q[RADIX_BITS-1:0]),
    .mcand_i(mcand_q),
    .pp_o   (pp)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. done_i only matters in WAIT, so a done coinciding with
  // the ISSUE pulse is dropped, and a start_i arriving with done_i in WAIT is
  // not accepted until the machine is actually back in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = MUL;
      MUL:     if (last_step) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    start_o = 1'b0;
    unique case (state_q)
      IDLE:    ready_o = 1'b1;
      MUL:     busy_o  = 1'b1;
      ISSUE: begin
        busy_o  = 1'b1;
        start_o = 1'b1;
      end
      WAIT:    busy_o  = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  // Datapath next values: operand capture on accept, one shift-add step per
  // MUL cycle, and the x_o transfer on the final step so x_o is settled
  // before start_o rises and stays put until the next product.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = DATA_LENGTH'(a_i);
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (state_q == MUL) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << RADIX_BITS;
      mplier_d = mplier_q >> RADIX_BITS;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_step) begin
        x_d = acc_sum;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
    end
  end

  assign x_o = x_q;

endmodule
